// File: rtl/cxu_mac_pkg.sv
// Shared opcodes, status codes, FSM states and response bundle.
// sat_mac serves the CXU_MAC_SAT_EN build.
package cxu_mac_pkg;

  localparam logic [2:0] OP_MAC = 3'd0;
  localparam logic [2:0] OP_RD  = 3'd1;
  localparam logic [2:0] OP_WR  = 3'd2;
  localparam logic [2:0] OP_CLR = 3'd3;
  localparam logic [2:0] OP_HAM = 3'd4;

  localparam logic [2:0] ST_OK        = 3'd0;
  localparam logic [2:0] ST_BAD_FUNC  = 3'd1;
  localparam logic [2:0] ST_BAD_STATE = 3'd2;
  localparam logic [2:0] ST_BAD_CXU   = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_ACC
  } fsm_e;

  typedef struct packed {
    logic        valid;
    logic        state;
    logic [3:0]  status;
    logic [31:0] data;
  } resp_t;

  // Clamp the 64-bit signed product to 32 bits, then saturating add.
  function automatic logic [31:0] sat_mac(
    input logic [31:0] acc,
    input logic [63:0] prod
  );
    logic [31:0] pc;
    logic [32:0] s;
    if ((&prod[63:31]) | ~(|prod[63:31]))
      pc = prod[31:0];
    else
      pc = prod[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    s = {acc[31], acc} + {pc[31], pc};
    if (s[32] == s[31])
      return s[31:0];
    return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

endpackage

// File: rtl/cxu_iter_mul.sv
// Iterative 32x32 multiplier, MUL_BITS of B per cycle, LSB first.
// With CXU_MAC_SAT_EN the product is corrected to signed 64-bit.
module cxu_iter_mul #(
  parameter int MUL_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        start,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        last_o,
  output logic [63:0] prod_o
);

  localparam int N_ITER = 32 / MUL_BITS;
  localparam int CW = $clog2(N_ITER) + 1;
  localparam int ZW = 64 - MUL_BITS;

  logic [63:0]   mc_q, mc_d;
  logic [63:0]   p_q, p_d;
  logic [31:0]   mp_q, mp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  // The start edge already retires chunk 0.
  assign last_o = busy_q && (cnt_q == CW'(N_ITER - 1));

  always_comb begin
    mc_d   = mc_q;
    mp_d   = mp_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      p_d    = {32'b0, a_i} * {{ZW{1'b0}}, b_i[MUL_BITS-1:0]};
      mc_d   = {32'b0, a_i} << MUL_BITS;
      mp_d   = b_i >> MUL_BITS;
      cnt_d  = CW'(1);
      busy_d = (N_ITER > 1);
    end else if (busy_q) begin
      p_d    = p_q + mc_q * {{ZW{1'b0}}, mp_q[MUL_BITS-1:0]};
      mc_d   = mc_q << MUL_BITS;
      mp_d   = mp_q >> MUL_BITS;
      cnt_d  = cnt_q + CW'(1);
      busy_d = !last_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_q   <= '0;
      mp_q   <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      mc_q   <= mc_d;
      mp_q   <= mp_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

`ifdef CXU_MAC_SAT_EN
  logic [31:0] a0_q, a0_d;
  logic [31:0] b0_q, b0_d;

  always_comb begin
    a0_d = a0_q;
    b0_d = b0_q;
    if (start && !abort) begin
      a0_d = a_i;
      b0_d = b_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0_q <= '0;
      b0_q <= '0;
    end else begin
      a0_q <= a0_d;
      b0_q <= b0_d;
    end
  end

  // Unsigned product minus the two's-complement sign terms.
  assign prod_o = p_q
                - (a0_q[31] ? {b0_q, 32'b0} : 64'b0)
                - (b0_q[31] ? {a0_q, 32'b0} : 64'b0);
`else
  assign prod_o = p_q;
`endif

endmodule

// File: rtl/cxu_mac_responder.sv
// CX responder: multi-context MAC unit plus single-cycle helper ops.
// Define CXU_MAC_SAT_EN for signed saturating MAC.
module cxu_mac_responder
  import cxu_mac_pkg::*;
#(
  parameter logic [1:0] CXU_ID     = 2'd0,
  parameter int         NUM_STATES = 4,
  parameter int         MUL_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cx_rst,
  input  logic        cx_req_valid,
  input  logic [1:0]  cx_cxu_id,
  input  logic [1:0]  cx_state_id,
  input  logic [1:0]  cx_virt_state_id,
  input  logic [31:0] cx_insn,
  input  logic [24:0] cx_func,
  input  logic [31:0] cx_req_data0,
  input  logic [31:0] cx_req_data1,
  output logic        cx_resp_valid,
  output logic        cx_resp_state,
  output logic [3:0]  cx_resp_status,
  output logic [31:0] cx_resp_data
);

  localparam int N_ITER = 32 / MUL_BITS;

  fsm_e        state_q, state_d;
  logic [31:0] acc_q[4];
  logic [31:0] acc_d[4];
  logic [3:0]  dirty_q, dirty_d;
  logic [1:0]  sid_q, sid_d;
  logic        ovr_q, ovr_d;
  resp_t       resp_q, resp_d;
  logic        mul_start, mul_last;
  logic [63:0] prod;
  logic [31:0] mac_sum;
  logic [2:0]  op, err;
  logic        unused_ok;

  assign op = cx_func[2:0];

  cxu_iter_mul #(.MUL_BITS(MUL_BITS)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .abort  (cx_rst),
    .start  (mul_start),
    .a_i    (cx_req_data0),
    .b_i    (cx_req_data1),
    .last_o (mul_last),
    .prod_o (prod)
  );

`ifdef CXU_MAC_SAT_EN
  assign mac_sum = sat_mac(acc_q[sid_q], prod);
  assign unused_ok = ^{cx_virt_state_id, cx_insn,
                       cx_func[24:3]};
`else
  assign mac_sum = acc_q[sid_q] + prod[31:0];
  assign unused_ok = ^{cx_virt_state_id, cx_insn,
                       cx_func[24:3], prod[63:32]};
`endif

  always_comb begin
    err = ST_OK;
    if (cx_cxu_id != CXU_ID)
      err = ST_BAD_CXU;
    else if (int'(cx_state_id) >= NUM_STATES)
      err = ST_BAD_STATE;
    else if (op > OP_HAM)
      err = ST_BAD_FUNC;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    dirty_d   = dirty_q;
    sid_d     = sid_q;
    ovr_d     = ovr_q;
    resp_d    = resp_q;
    resp_d.valid = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cx_req_valid) begin
          if (err == ST_OK && op == OP_MAC) begin
            mul_start = 1'b1;
            sid_d     = cx_state_id;
            ovr_d     = 1'b0;
            state_d   = (N_ITER == 1) ? S_ACC : S_MUL;
          end else begin
            resp_d.valid  = 1'b1;
            resp_d.state  = 1'b0;
            resp_d.status = {1'b0, err};
            resp_d.data   = '0;
            if (err == ST_OK) begin
              resp_d.state = dirty_q[cx_state_id];
              case (op)
                OP_RD:
                  resp_d.data = acc_q[cx_state_id];
                OP_WR: begin
                  resp_d.data  = acc_q[cx_state_id];
                  resp_d.state = 1'b1;
                  acc_d[cx_state_id]   = cx_req_data0;
                  dirty_d[cx_state_id] = 1'b1;
                end
                OP_CLR: begin
                  resp_d.state = 1'b0;
                  acc_d[cx_state_id]   = '0;
                  dirty_d[cx_state_id] = 1'b0;
                end
                OP_HAM:
                  resp_d.data = 32'($countones(
                    cx_req_data0 ^ cx_req_data1));
                default: ;
              endcase
            end
          end
        end
      end
      S_MUL: begin
        if (cx_req_valid) ovr_d = 1'b1;
        if (mul_last) state_d = S_ACC;
      end
      S_ACC: begin
        acc_d[sid_q]   = mac_sum;
        dirty_d[sid_q] = 1'b1;
        resp_d.valid   = 1'b1;
        resp_d.state   = 1'b1;
        resp_d.status  = {ovr_q | cx_req_valid, ST_OK};
        resp_d.data    = mac_sum;
        ovr_d          = 1'b0;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Soft reset wins over any request or op in flight.
    if (cx_rst) begin
      state_d   = S_IDLE;
      acc_d     = '{default: '0};
      dirty_d   = '0;
      sid_d     = '0;
      ovr_d     = 1'b0;
      resp_d    = '0;
      mul_start = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '{default: '0};
      dirty_q <= '0;
      sid_q   <= '0;
      ovr_q   <= 1'b0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dirty_q <= dirty_d;
      sid_q   <= sid_d;
      ovr_q   <= ovr_d;
      resp_q  <= resp_d;
    end
  end

  assign cx_resp_valid  = resp_q.valid;
  assign cx_resp_state  = resp_q.state;
  assign cx_resp_status = resp_q.status;
  assign cx_resp_data   = resp_q.data;

endmodule

// File: tb/tb_cxu_mac_responder.sv
// Bench for cxu_mac_responder: directed scenarios plus random ops
// against a context-array model. Honours CXU_MAC_SAT_EN.
module tb_cxu_mac_responder;

  localparam int NS  = 2;
  localparam int MB  = 8;
  localparam int MAC_LAT = 32 / MB + 1;
  localparam longint MAXV = 64'sh7FFF_FFFF;
  localparam longint MINV = -64'sh8000_0000;

  logic        clk = 1'b0;
  logic        rst, cx_rst, cx_req_valid;
  logic [1:0]  cx_cxu_id, cx_state_id, cx_virt_state_id;
  logic [31:0] cx_insn, d0, d1;
  logic [24:0] cx_func;
  logic        cx_resp_valid, cx_resp_state;
  logic [3:0]  cx_resp_status;
  logic [31:0] cx_resp_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_acc[NS];
  logic        m_dirty[NS];

  cxu_mac_responder #(
    .CXU_ID(2'd0), .NUM_STATES(NS), .MUL_BITS(MB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cx_rst           (cx_rst),
    .cx_req_valid     (cx_req_valid),
    .cx_cxu_id        (cx_cxu_id),
    .cx_state_id      (cx_state_id),
    .cx_virt_state_id (cx_virt_state_id),
    .cx_insn          (cx_insn),
    .cx_func          (cx_func),
    .cx_req_data0     (d0),
    .cx_req_data1     (d1),
    .cx_resp_valid    (cx_resp_valid),
    .cx_resp_state    (cx_resp_state),
    .cx_resp_status   (cx_resp_status),
    .cx_resp_data     (cx_resp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mac_ref(
    input logic [31:0] acc, a, b);
`ifdef CXU_MAC_SAT_EN
    longint p, s;
    p = longint'($signed(a)) * longint'($signed(b));
    if (p > MAXV) p = MAXV;
    else if (p < MINV) p = MINV;
    s = longint'($signed(acc)) + p;
    if (s > MAXV) s = MAXV;
    else if (s < MINV) s = MINV;
    return s[31:0];
`else
    return acc + a * b;
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_acc[i]   = '0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic model(
    input  logic [2:0]  op,
    input  logic [1:0]  cxu, sid,
    input  logic [31:0] a, b,
    output int          lat,
    output logic [3:0]  st,
    output logic [31:0] dat,
    output logic        ds);
    int s;
    s = sid;
    lat = 1; dat = '0; ds = 1'b0; st = 4'd0;
    if (cxu != 2'd0) st = 4'd3;
    else if (s >= NS) st = 4'd2;
    else if (op > 3'd4) st = 4'd1;
    else begin
      case (op)
        3'd0: begin
          m_acc[s] = mac_ref(m_acc[s], a, b);
          m_dirty[s] = 1'b1;
          dat = m_acc[s]; ds = 1'b1; lat = MAC_LAT;
        end
        3'd1: begin dat = m_acc[s]; ds = m_dirty[s]; end
        3'd2: begin
          dat = m_acc[s]; m_acc[s] = a;
          m_dirty[s] = 1'b1; ds = 1'b1;
        end
        3'd3: begin m_acc[s] = '0; m_dirty[s] = 1'b0; end
        default: begin
          dat = 32'($countones(a ^ b)); ds = m_dirty[s];
        end
      endcase
    end
  endtask

  task automatic drive(
    input logic [2:0] op, input logic [1:0] cxu, sid,
    input logic [31:0] a, b);
    cx_req_valid     = 1'b1;
    cx_cxu_id        = cxu;
    cx_state_id      = sid;
    cx_virt_state_id = 2'($urandom());
    cx_insn          = $urandom();
    cx_func          = {22'($urandom()), op};
    d0 = a;
    d1 = b;
  endtask

  task automatic idle();
    cx_req_valid = 1'b0;
  endtask

  // Issue one request, return latency (0 = none) and response.
  task automatic run_op(
    input  logic [2:0]  op,
    input  logic [1:0]  cxu, sid,
    input  logic [31:0] a, b,
    output int          lat,
    output logic [3:0]  st,
    output logic [31:0] dat,
    output logic        ds);
    lat = 0; st = '0; dat = '0; ds = 1'b0;
    @(negedge clk);
    drive(op, cxu, sid, a, b);
    @(negedge clk);
    idle();
    for (int k = 1; k <= 12; k++) begin
      if (cx_resp_valid) begin
        lat = k; st = cx_resp_status;
        dat = cx_resp_data; ds = cx_resp_state;
        break;
      end
      @(negedge clk);
    end
  endtask

  int          lat, elat;
  logic [3:0]  st, est;
  logic [31:0] dat, edat;
  logic        ds, eds;

  task automatic op_check(
    input string nm, input logic [2:0] op,
    input logic [1:0] cxu, sid, input logic [31:0] a, b);
    model(op, cxu, sid, a, b, elat, est, edat, eds);
    run_op(op, cxu, sid, a, b, lat, st, dat, ds);
    n_tests++;
    if (lat !== elat || st !== est || dat !== edat
        || (est == 4'd0 && ds !== eds)) begin
      n_fail++;
      $display("FAIL %s got lat=%0d st=%h d=%h s=%b exp lat=%0d st=%h d=%h s=%b",
        nm, lat, st, dat, ds, elat, est, edat, eds);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cx_rst = 1'b0; idle();
    cx_cxu_id = '0; cx_state_id = '0;
    cx_virt_state_id = '0; cx_insn = '0;
    cx_func = '0; d0 = '0; d1 = '0;
    model_clear();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({cx_resp_valid, cx_resp_state, cx_resp_status,
         cx_resp_data} !== 38'b0) begin
      n_fail++;
      $display("FAIL reset outs got v=%b s=%b st=%h d=%h exp 0",
        cx_resp_valid, cx_resp_state, cx_resp_status,
        cx_resp_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_wr_rd();
    op_check("wr_s0", 3'd2, 2'd0, 2'd0, 32'd5, 32'd0);
    op_check("rd_s0", 3'd1, 2'd0, 2'd0, 32'd0, 32'd0);
    @(negedge clk);
    n_tests++;
    if (cx_resp_valid !== 1'b0 || cx_resp_data !== 32'd5) begin
      n_fail++;
      $display("FAIL hold got v=%b d=%h exp v=0 d=5",
        cx_resp_valid, cx_resp_data);
    end
  endtask

  task automatic test_mac();
    op_check("clr_s1", 3'd3, 2'd0, 2'd1, 32'd0, 32'd0);
    op_check("mac_3x7", 3'd0, 2'd0, 2'd1, 32'd3, 32'd7);
    op_check("mac_wrap", 3'd0, 2'd0, 2'd1,
             32'hFFFF_FFFF, 32'd2);
    op_check("wr_max", 3'd2, 2'd0, 2'd1,
             32'h7FFF_FFFF, 32'd0);
    op_check("mac_max", 3'd0, 2'd0, 2'd1, 32'd1, 32'd1);
    op_check("mac_big", 3'd0, 2'd0, 2'd0,
             32'h8000_0001, 32'h7FFF_0003);
    op_check("rd_s1", 3'd1, 2'd0, 2'd1, 32'd0, 32'd0);
  endtask

  task automatic test_errors();
    op_check("bad_cxu", 3'd2, 2'd1, 2'd0, 32'hDEAD, 32'd0);
    op_check("bad_st3", 3'd2, 2'd0, 2'd3, 32'hBEEF, 32'd0);
    op_check("bad_st2", 3'd0, 2'd0, 2'd2, 32'd9, 32'd9);
    op_check("bad_op6", 3'd6, 2'd0, 2'd0, 32'h1234, 32'd0);
    op_check("bad_op5", 3'd5, 2'd0, 2'd1, 32'h1, 32'd0);
    op_check("cxu_vs_st", 3'd7, 2'd2, 2'd3, 32'h1, 32'd0);
    op_check("err_rd0", 3'd1, 2'd0, 2'd0, 32'd0, 32'd0);
    op_check("err_rd1", 3'd1, 2'd0, 2'd1, 32'd0, 32'd0);
  endtask

  task automatic test_overrun(input int drop_k);
    int cnt, got_k;
    logic [31:0] a, b;
    a = $urandom(); b = $urandom();
    model(3'd0, 2'd0, 2'd0, a, b, elat, est, edat, eds);
    cnt = 0; got_k = 0; st = '0; dat = '0;
    @(negedge clk);
    drive(3'd0, 2'd0, 2'd0, a, b);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) idle();
      if (cx_resp_valid) begin
        cnt++; got_k = k;
        st = cx_resp_status; dat = cx_resp_data;
      end
      if (k == drop_k) drive(3'd2, 2'd0, 2'd0, 32'hBAD, 0);
      if (k == drop_k + 1) idle();
    end
    n_tests++;
    if (cnt !== 1 || got_k !== MAC_LAT) begin
      n_fail++;
      $display("FAIL ovr_count k%0d got n=%0d at %0d exp 1 at %0d",
        drop_k, cnt, got_k, MAC_LAT);
    end
    n_tests++;
    if (st !== 4'b1000 || dat !== edat) begin
      n_fail++;
      $display("FAIL ovr_resp k%0d got st=%h d=%h exp st=8 d=%h",
        drop_k, st, dat, edat);
    end
    op_check("ovr_rd", 3'd1, 2'd0, 2'd0, 32'd0, 32'd0);
  endtask

  task automatic test_back_to_back();
    logic v1, v2, v3;
    logic [31:0] r1, r2, r3;
    int k5;
    @(negedge clk);
    drive(3'd4, 2'd0, 2'd0, 32'hFF, 32'h0F);
    @(negedge clk);
    v1 = cx_resp_valid; r1 = cx_resp_data;
    drive(3'd4, 2'd0, 2'd1, 32'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    v2 = cx_resp_valid; r2 = cx_resp_data;
    idle();
    @(negedge clk);
    v3 = cx_resp_valid; r3 = cx_resp_data;
    n_tests++;
    if (v1 !== 1'b1 || r1 !== 32'd4) begin
      n_fail++;
      $display("FAIL b2b_ham1 got v=%b d=%h exp v=1 d=4", v1, r1);
    end
    n_tests++;
    if (v2 !== 1'b1 || r2 !== 32'd32) begin
      n_fail++;
      $display("FAIL b2b_ham2 got v=%b d=%h exp v=1 d=20", v2, r2);
    end
    n_tests++;
    if (v3 !== 1'b0 || r3 !== 32'd32) begin
      n_fail++;
      $display("FAIL b2b_idle got v=%b d=%h exp v=0 d=20", v3, r3);
    end
    // Follow a MAC with a read in its response cycle.
    model(3'd0, 2'd0, 2'd1, 32'd11, 32'd13, elat, est, edat, eds);
    k5 = 0;
    @(negedge clk);
    drive(3'd0, 2'd0, 2'd1, 32'd11, 32'd13);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) idle();
      if (cx_resp_valid) begin
        k5 = k;
        drive(3'd1, 2'd0, 2'd1, 32'd0, 32'd0);
        break;
      end
    end
    @(negedge clk);
    idle();
    n_tests++;
    if (k5 !== MAC_LAT || cx_resp_valid !== 1'b1
        || cx_resp_data !== edat) begin
      n_fail++;
      $display("FAIL mac_then_rd got k=%0d v=%b d=%h exp k=%0d v=1 d=%h",
        k5, cx_resp_valid, cx_resp_data, MAC_LAT, edat);
    end
  endtask

  task automatic test_cx_rst();
    int cnt;
    op_check("pre_wr", 3'd2, 2'd0, 2'd0, 32'h55, 32'd0);
    cnt = 0;
    @(negedge clk);
    drive(3'd0, 2'd0, 2'd0, 32'd3, 32'd3);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) idle();
      if (cx_resp_valid) cnt++;
      if (k == 2) cx_rst = 1'b1;
      if (k == 3) cx_rst = 1'b0;
    end
    model_clear();
    n_tests++;
    if (cnt !== 0) begin
      n_fail++;
      $display("FAIL cxrst_abort got %0d resps exp 0", cnt);
    end
    @(negedge clk);
    drive(3'd2, 2'd0, 2'd1, 32'h77, 32'd0);
    cx_rst = 1'b1;
    @(negedge clk);
    idle();
    cx_rst = 1'b0;
    cnt = 0;
    repeat (3) begin
      if (cx_resp_valid) cnt++;
      @(negedge clk);
    end
    n_tests++;
    if (cnt !== 0) begin
      n_fail++;
      $display("FAIL cxrst_req got %0d resps exp 0", cnt);
    end
    op_check("cxrst_rd0", 3'd1, 2'd0, 2'd0, 32'd0, 32'd0);
    op_check("cxrst_rd1", 3'd1, 2'd0, 2'd1, 32'd0, 32'd0);
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [1:0]  cxu, sid;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0)
        op = 3'($urandom_range(0, 4));
      cxu = ($urandom_range(0, 9) == 0) ?
            2'($urandom_range(1, 3)) : 2'd0;
      sid = 2'($urandom_range(0, 2));
      a = $urandom(); b = $urandom();
      if ($urandom_range(0, 2) == 0) b = b & 32'hFF;
      op_check("random", op, cxu, sid, a, b);
    end
  endtask

  task automatic test_async_rst();
    op_check("pre_ham", 3'd4, 2'd0, 2'd0,
             32'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(3'd0, 2'd0, 2'd1, 32'd5, 32'd5);
    @(negedge clk);
    idle();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({cx_resp_valid, cx_resp_state, cx_resp_status,
         cx_resp_data} !== 38'b0) begin
      n_fail++;
      $display("FAIL async_rst got v=%b s=%b st=%h d=%h exp 0",
        cx_resp_valid, cx_resp_state, cx_resp_status,
        cx_resp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    op_check("arst_rd1", 3'd1, 2'd0, 2'd1, 32'd0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_wr_rd();
    test_mac();
    test_errors();
    test_overrun(2);
    test_overrun(4);
    test_back_to_back();
    test_cx_rst();
    test_random();
    test_async_rst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
